// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_fetch_responder_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [1:0] buf_state_t;
  localparam buf_state_t BUF_EMPTY = 2'd0;
  localparam buf_state_t BUF_ONE   = 2'd1;
  localparam buf_state_t BUF_FULL  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
    logic            err;
  } imem_resp_t;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response, flush and program-load bus; resp_err exists only with IMEM_ERR_EN.
interface imem_fetch_responder_if;
  import imem_fetch_responder_pkg::*;

  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_instr;
  logic [XLEN-1:0] resp_addr;
  logic            wr_en;
  logic [XLEN-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
`ifdef IMEM_ERR_EN
  logic            resp_err;
`endif

  modport master (
    output flush, req_valid, req_addr, resp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, resp_valid, resp_instr, resp_addr
`ifdef IMEM_ERR_EN
    , input resp_err
`endif
  );

  modport slave (
    input  flush, req_valid, req_addr, resp_ready, wr_en, wr_addr, wr_data,
    output req_ready, resp_valid, resp_instr, resp_addr
`ifdef IMEM_ERR_EN
    , output resp_err
`endif
  );

endinterface

// File: rtl/imem_fetch_responder_resp_fifo.sv
// Two-entry response buffer with synchronous clear; occupancy tracked by a 3-state FSM.
module imem_fetch_responder_resp_fifo
  import imem_fetch_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  imem_resp_t push_data_i,
  output imem_resp_t head_o,
  output logic [1:0] count_o,
  output buf_state_t state_o
);

  buf_state_t state_q, state_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  imem_resp_t entry_q [2];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUF_EMPTY: if (push_i) state_d = BUF_ONE;
      BUF_ONE: begin
        if (push_i && !pop_i)      state_d = BUF_FULL;
        else if (pop_i && !push_i) state_d = BUF_EMPTY;
      end
      BUF_FULL:  if (pop_i) state_d = BUF_ONE;
      default:   state_d = BUF_EMPTY;
    endcase
    if (clear_i) state_d = BUF_EMPTY;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_i;
    rd_ptr_d = rd_ptr_q ^ pop_i;
    if (clear_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BUF_EMPTY;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_i && !clear_i) entry_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = entry_q[rd_ptr_q];
  assign count_o = state_q;
  assign state_o = state_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: sync-read RAM, credit-limited 2-deep response buffer, flush.
// Optional IMEM_ERR_EN adds resp_err and NOP substitution for misaligned/out-of-range fetches.
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter string       INIT_FILE = ""
) (
  input logic                   clk,
  input logic                   rst,
  imem_fetch_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];

  logic            rdy_q;
  logic            inflight_q;
  logic            rd_err_q;
  logic [XLEN-1:0] rd_addr_q;
  logic [XLEN-1:0] rd_data_q;

  logic [AW-1:0] rd_idx, wr_idx;
  logic          req_err;
  logic          accept, push, pop;
  logic [1:0]    buf_count;
  buf_state_t    buf_state;
  imem_resp_t    push_data, head;
  logic          unused_bits;

  assign rd_idx = bus.req_addr[AW+1:2];
  assign wr_idx = bus.wr_addr[AW+1:2];

`ifdef IMEM_ERR_EN
  assign req_err       = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[XLEN-1:AW+2] != '0);
  assign bus.resp_err  = head.err;
  assign unused_bits   = ^{bus.wr_addr[XLEN-1:AW+2], bus.wr_addr[1:0]};
`else
  assign req_err     = 1'b0;
  assign unused_bits = ^{bus.wr_addr[XLEN-1:AW+2], bus.wr_addr[1:0],
                         bus.req_addr[XLEN-1:AW+2], bus.req_addr[1:0], head.err};
`endif

  // Credit counts the in-flight read; a flush frees the buffer, so it is treated as empty.
  assign bus.req_ready = rdy_q && (bus.flush || ((buf_count + {1'b0, inflight_q}) < 2'd2));
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q      <= 1'b0;
      inflight_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      rdy_q      <= 1'b1;
      inflight_q <= accept;
      if (accept) begin
        rd_err_q  <= req_err;
        rd_addr_q <= bus.req_addr;
      end
    end
  end

  // Read and write share an edge; the read samples the pre-write word.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[wr_idx] <= bus.wr_data;
    if (accept && !req_err) rd_data_q <= mem[rd_idx];
  end

  assign push            = inflight_q && !bus.flush;
  assign pop             = bus.resp_valid && bus.resp_ready;
  assign push_data.instr = rd_err_q ? NOP_INSTR : rd_data_q;
  assign push_data.addr  = rd_addr_q;
  assign push_data.err   = rd_err_q;

  imem_fetch_responder_resp_fifo u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (bus.flush),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_data),
    .head_o      (head),
    .count_o     (buf_count),
    .state_o     (buf_state)
  );

  assign bus.resp_valid = (buf_state != BUF_EMPTY);
  assign bus.resp_instr = head.instr;
  assign bus.resp_addr  = head.addr;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder with a queue-based reference model checked every cycle.
module tb_imem_fetch_responder;
  import imem_fetch_responder_pkg::*;

  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_fetch_responder_if bus ();

  imem_fetch_responder #(
    .DEPTH     (DEPTH),
    .INIT_FILE ("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    int          avail;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } got_t;

  exp_t        q[$];
  got_t        got[$];
  logic [31:0] shadow [DEPTH];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  bit          rdy_m  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every request outstanding (reading or buffered) is one queue entry.
  always @(negedge clk) begin : mon
    bit          ev, er, pop, acc;
    exp_t        e;
    logic        dut_err;
`ifdef IMEM_ERR_EN
    dut_err = bus.resp_err;
`else
    dut_err = 1'b0;
`endif
    if (rst) begin
      q.delete();
      rdy_m = 1'b0;
      chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("rst_resp_instr", bus.resp_instr, 32'd0);
      chk("rst_resp_addr", bus.resp_addr, 32'd0);
      chk("rst_resp_err", {31'b0, dut_err}, 32'd0);
    end else begin
      ev = (q.size() > 0) && (q[0].avail <= cyc);
      er = rdy_m && (bus.flush || (q.size() < 2));
      chk("req_ready", {31'b0, bus.req_ready}, {31'b0, er});
      chk("resp_valid", {31'b0, bus.resp_valid}, {31'b0, ev});
      if (ev) begin
        chk("resp_instr", bus.resp_instr, q[0].instr);
        chk("resp_addr", bus.resp_addr, q[0].addr);
        chk("resp_err", {31'b0, dut_err}, {31'b0, q[0].err});
      end
      pop = ev && bus.resp_ready;
      if (pop) got.push_back('{addr: bus.resp_addr, instr: bus.resp_instr, err: dut_err});
      if (bus.flush) q.delete();
      else if (pop) void'(q.pop_front());
      acc = bus.req_valid && er;
      if (acc) begin
        e.addr  = bus.req_addr;
        e.avail = cyc + 2;
`ifdef IMEM_ERR_EN
        e.err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= DEPTH * 4);
`else
        e.err = 1'b0;
`endif
        e.instr = e.err ? 32'h0000_0013 : shadow[(bus.req_addr >> 2) % DEPTH];
        q.push_back(e);
      end
      if (bus.wr_en) shadow[(bus.wr_addr >> 2) % DEPTH] = bus.wr_data;
      rdy_m = 1'b1;
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    #1;
    while (!bus.req_ready) begin
      if (n == 40) begin
        n_chk++;
        n_fail++;
        $display("FAIL req_timeout: addr %h never accepted", a);
        break;
      end
      @(posedge clk);
      #2;
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  logic [31:0] prog [3];

  initial begin
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0050_0093;
    prog[2] = 32'hFFF0_0113;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;

    step(3);
    rst = 1'b0;
    step(1);
    chk("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = i * 4;
      bus.wr_data = (i < 3) ? prog[i] : (32'hA000_0000 | i);
      step(1);
    end
    bus.wr_en = 1'b0;

    // In-order stream with consumer always ready.
    bus.resp_ready = 1'b1;
    req(32'h0);
    req(32'h4);
    req(32'h8);
    step(6);
    chk("stream_count", got.size(), 32'd3);
    chk("stream0_instr", got[0].instr, 32'h0000_0013);
    chk("stream1_instr", got[1].instr, 32'h0050_0093);
    chk("stream2_instr", got[2].instr, 32'hFFF0_0113);
    chk("stream2_addr", got[2].addr, 32'h8);
    got.delete();

    // Backpressure: two credits, then stall until released.
    bus.resp_ready = 1'b0;
    req(32'h0);
    req(32'h4);
    #1;
    chk("bp_ready_low", {31'b0, bus.req_ready}, 32'd0);
    step(3);
    chk("bp_hold_instr", bus.resp_instr, 32'h0000_0013);
    bus.resp_ready = 1'b1;
    step(4);
    chk("bp_count", got.size(), 32'd2);
    chk("bp0_addr", got[0].addr, 32'h0);
    chk("bp1_instr", got[1].instr, 32'h0050_0093);
    got.delete();

    // Flush drops the older fetch and keeps the redirected one.
    req(32'h10);
    bus.flush = 1'b1;
    req(32'h40);
    bus.flush = 1'b0;
    step(4);
    chk("flush_count", got.size(), 32'd1);
    chk("flush_addr", got[0].addr, 32'h40);
    chk("flush_instr", got[0].instr, 32'hA000_0010);
    got.delete();

    // Same-word write during read returns the old word.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 32'hC;
    bus.wr_data = 32'hDEAD_BEEF;
    req(32'hC);
    bus.wr_en = 1'b0;
    step(3);
    req(32'hC);
    step(3);
    chk("wr_count", got.size(), 32'd2);
    chk("wr_old", got[0].instr, 32'hA000_0003);
    chk("wr_new", got[1].instr, 32'hDEAD_BEEF);
    got.delete();

`ifdef IMEM_ERR_EN
    req(32'h6);
    req(DEPTH * 4);
    req(32'h0);
    step(5);
    chk("err_count", got.size(), 32'd3);
    chk("err0_instr", got[0].instr, 32'h0000_0013);
    chk("err0_flag", {31'b0, got[0].err}, 32'd1);
    chk("err1_flag", {31'b0, got[1].err}, 32'd1);
    chk("err1_addr", got[1].addr, DEPTH * 4);
    chk("err2_flag", {31'b0, got[2].err}, 32'd0);
    got.delete();
`endif

    // Asynchronous reset with a full buffer.
    bus.resp_ready = 1'b0;
    req(32'h0);
    req(32'h8);
    step(2);
    chk("full_valid", {31'b0, bus.resp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("async_ready", {31'b0, bus.req_ready}, 32'd0);
    step(2);
    rst = 1'b0;
    #1;
    chk("release_ready_low", {31'b0, bus.req_ready}, 32'd0);
    step(1);
    chk("release_ready_high", {31'b0, bus.req_ready}, 32'd1);
    bus.resp_ready = 1'b1;
    req(32'h4);
    step(4);
    chk("post_rst_count", got.size(), 32'd1);
    chk("post_rst_instr", got[0].instr, 32'h0050_0093);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
